// File: rtl/rail_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rail_pkg
// Description : Shared constants, heal-mode encoding and fare helper.
// Revision    : 1.0
// ============================================================================
package rail_pkg;

  localparam logic [3:0] SEATS     = 4'd10;
  localparam logic [9:0] RATE0     = 10'd5;
  localparam logic [9:0] RATE1     = 10'd6;
  localparam logic [9:0] COMP_FARE = 10'd50;
  localparam logic [2:0] PRED_TH   = 3'd2;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_COMP = 2'b01,
    MODE_SEAT = 2'b10,
    MODE_FULL = 2'b11
  } heal_mode_e;

  // Worst case 7 hops * 15 tickets * 6 = 630, so 10 bits never overflow.
  function automatic logic [9:0] calc_fare(input logic       train,
                                           input logic [2:0] hops,
                                           input logic [3:0] tickets);
    logic [9:0] h, t, r;
    h = {7'b0, hops};
    t = {6'b0, tickets};
    r = train ? RATE1 : RATE0;
    return h * t * r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fault_detect_unit.sv
`default_nettype none
// ============================================================================
// Module      : fault_detect_unit
// Description : Flags seat counters that overflow or disagree with shadows.
// Revision    : 1.0
// ============================================================================
module fault_detect_unit
  import rail_pkg::*;
(
  input  logic [3:0] cnt0_i,
  input  logic [3:0] cnt1_i,
  input  logic [3:0] shadow0_i,
  input  logic [3:0] shadow1_i,
  output logic       fault_flag
);

  logic w_overflow;
  logic w_mismatch;

  assign w_overflow = (cnt0_i > SEATS) || (cnt1_i > SEATS);
  assign w_mismatch = (cnt0_i != shadow0_i) || (cnt1_i != shadow1_i);
  assign fault_flag = w_overflow || w_mismatch;

endmodule
`default_nettype wire

// File: rtl/multi_train_self_healing.sv
`default_nettype none
// ============================================================================
// Module      : multi_train_self_healing
// Description : Two-train booking engine with fault detection and graded heal.
// Revision    : 1.0
// ============================================================================
module multi_train_self_healing
  import rail_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       book_req,
  input  logic       train_id,
  input  logic [2:0] src,
  input  logic [2:0] dest,
  input  logic [3:0] num_tickets,
  output logic       success,
  output logic [3:0] booked_count,
  output logic [9:0] fare,
  output logic       fault_flag,
  output logic       predict_flag,
  output logic       heal_trigger,
  output logic [1:0] heal_mode
);

  logic [1:0][3:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic            last_train_q, last_train_d;
  logic            fault_q, fault_d;
  logic [2:0]      fault_cnt_q, fault_cnt_d;
  logic            heal_pend_q, heal_pend_d;
  logic            heal_trigger_q, heal_trigger_d;
  heal_mode_e      heal_mode_q, heal_mode_d;
  logic            predict_q, predict_d;
  logic            success_q, success_d;
  logic [9:0]      fare_q, fare_d;

  logic            w_fault;
  logic            w_rise;
  logic [4:0]      w_sum;
  logic            w_accept;
  logic [10:0]     w_fare_comp;

  fault_detect_unit fdu (
    .cnt0_i    (cnt_q[0]),
    .cnt1_i    (cnt_q[1]),
    .shadow0_i (shadow_q[0]),
    .shadow1_i (shadow_q[1]),
    .fault_flag(w_fault)
  );

  assign w_rise      = w_fault & ~fault_q;
  assign w_sum       = {1'b0, cnt_q[train_id]} + {1'b0, num_tickets};
  assign w_accept    = (dest > src) && (num_tickets != 4'd0) && (w_sum <= {1'b0, SEATS});
  assign w_fare_comp = {1'b0, fare_q} + {1'b0, COMP_FARE};

  always_comb begin
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    last_train_d   = last_train_q;
    fault_d        = w_fault;
    fault_cnt_d    = fault_cnt_q;
    heal_pend_d    = 1'b0;
    heal_trigger_d = 1'b0;
    heal_mode_d    = heal_mode_q;
    predict_d      = predict_q;
    success_d      = success_q;
    fare_d         = fare_q;

    if (w_rise) begin
      heal_pend_d = 1'b1;
      if (fault_cnt_q != 3'd7) fault_cnt_d = fault_cnt_q + 3'd1;
      if (fault_cnt_d >= PRED_TH) predict_d = 1'b1;
    end

    // A pending heal owns this edge; any simultaneous booking is discarded.
    if (heal_pend_q) begin
      heal_trigger_d = 1'b1;
      if (book_req) success_d = 1'b0;
      if (fault_cnt_q == 3'd1) begin
        heal_mode_d = MODE_COMP;
        fare_d      = w_fare_comp[10] ? 10'h3FF : w_fare_comp[9:0];
      end else if (fault_cnt_q == 3'd2) begin
        heal_mode_d = MODE_SEAT;
        if (cnt_q[last_train_q] != 4'd0)
          cnt_d[last_train_q] = cnt_q[last_train_q] - 4'd1;
        if (shadow_q[last_train_q] != 4'd0)
          shadow_d[last_train_q] = shadow_q[last_train_q] - 4'd1;
      end else begin
        heal_mode_d = MODE_FULL;
        cnt_d       = '0;
        shadow_d    = '0;
        fare_d      = 10'd0;
        success_d   = 1'b0;
      end
    end else if (book_req) begin
      last_train_d = train_id;
      if (w_accept) begin
        cnt_d[train_id]    = w_sum[3:0];
        shadow_d[train_id] = shadow_q[train_id] + num_tickets;
        success_d          = 1'b1;
        fare_d             = calc_fare(train_id, dest - src, num_tickets);
      end else begin
        success_d = 1'b0;
        fare_d    = 10'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      shadow_q       <= '0;
      last_train_q   <= 1'b0;
      fault_q        <= 1'b0;
      fault_cnt_q    <= 3'd0;
      heal_pend_q    <= 1'b0;
      heal_trigger_q <= 1'b0;
      heal_mode_q    <= MODE_NONE;
      predict_q      <= 1'b0;
      success_q      <= 1'b0;
      fare_q         <= 10'd0;
    end else begin
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      last_train_q   <= last_train_d;
      fault_q        <= fault_d;
      fault_cnt_q    <= fault_cnt_d;
      heal_pend_q    <= heal_pend_d;
      heal_trigger_q <= heal_trigger_d;
      heal_mode_q    <= heal_mode_d;
      predict_q      <= predict_d;
      success_q      <= success_d;
      fare_q         <= fare_d;
    end
  end

  assign success      = success_q;
  assign booked_count = cnt_q[last_train_q];
  assign fare         = fare_q;
  assign fault_flag   = w_fault;
  assign predict_flag = predict_q;
  assign heal_trigger = heal_trigger_q;
  assign heal_mode    = heal_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_train_self_healing.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_train_self_healing
// Description : Directed bench for the two-train booking and healing engine.
// Revision    : 1.0
// ============================================================================
module tb_multi_train_self_healing;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       book_req = 1'b0;
  logic       train_id = 1'b0;
  logic [2:0] src = 3'd0;
  logic [2:0] dest = 3'd0;
  logic [3:0] num_tickets = 4'd0;
  wire        success;
  wire  [3:0] booked_count;
  wire  [9:0] fare;
  wire        fault_flag;
  wire        predict_flag;
  wire        heal_trigger;
  wire  [1:0] heal_mode;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  multi_train_self_healing dut (
    .clk         (clk),
    .rst         (rst),
    .book_req    (book_req),
    .train_id    (train_id),
    .src         (src),
    .dest        (dest),
    .num_tickets (num_tickets),
    .success     (success),
    .booked_count(booked_count),
    .fare        (fare),
    .fault_flag  (fault_flag),
    .predict_flag(predict_flag),
    .heal_trigger(heal_trigger),
    .heal_mode   (heal_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Request is presented on a negedge and its result sampled on the next one.
  task automatic book(input logic t, input logic [2:0] s, input logic [2:0] d,
                      input logic [3:0] n);
    book_req    = 1'b1;
    train_id    = t;
    src         = s;
    dest        = d;
    num_tickets = n;
    @(negedge clk);
    book_req = 1'b0;
  endtask

  // Forced pulse spans exactly one posedge; the heal executes one edge later.
  task automatic pulse_fault();
    force dut.fdu.fault_flag = 1'b1;
    #7;
    release dut.fdu.fault_flag;
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_success", success, 0);
    chk("rst_booked", booked_count, 0);
    chk("rst_fare", fare, 0);
    chk("rst_fault", fault_flag, 0);
    chk("rst_predict", predict_flag, 0);
    chk("rst_trigger", heal_trigger, 0);
    chk("rst_mode", heal_mode, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    book(1'b0, 3'd0, 3'd2, 4'd3);
    chk("b0_success", success, 1);
    chk("b0_fare", fare, 30);
    chk("b0_booked", booked_count, 3);
    chk("b0_fault", fault_flag, 0);

    pulse_fault();
    chk("h1_no_early_trig", heal_trigger, 0);
    @(negedge clk);
    chk("h1_trigger", heal_trigger, 1);
    chk("h1_mode", heal_mode, 1);
    chk("h1_fare", fare, 80);
    chk("h1_predict", predict_flag, 0);
    @(negedge clk);
    chk("h1_trig_one_cycle", heal_trigger, 0);

    pulse_fault();
    @(negedge clk);
    chk("h2_trigger", heal_trigger, 1);
    chk("h2_mode", heal_mode, 2);
    chk("h2_booked", booked_count, 2);
    chk("h2_predict", predict_flag, 1);
    chk("h2_fare_kept", fare, 80);
    chk("h2_fault_clear", fault_flag, 0);
    @(negedge clk);

    pulse_fault();
    @(negedge clk);
    chk("h3_trigger", heal_trigger, 1);
    chk("h3_mode", heal_mode, 3);
    chk("h3_fare", fare, 0);
    chk("h3_booked", booked_count, 0);
    chk("h3_success", success, 0);
    @(negedge clk);

    pulse_fault();
    @(negedge clk);
    chk("h4_trigger", heal_trigger, 1);
    chk("h4_mode", heal_mode, 3);
    chk("h4_fare", fare, 0);
    chk("h4_booked", booked_count, 0);
    @(negedge clk);

    book(1'b1, 3'd1, 3'd3, 4'd2);
    chk("b1_success", success, 1);
    chk("b1_fare", fare, 24);
    chk("b1_booked", booked_count, 2);

    book(1'b1, 3'd3, 3'd3, 4'd1);
    chk("same_stn_success", success, 0);
    chk("same_stn_fare", fare, 0);
    chk("same_stn_booked", booked_count, 2);

    book(1'b1, 3'd4, 3'd2, 4'd1);
    chk("rev_success", success, 0);

    book(1'b1, 3'd0, 3'd1, 4'd0);
    chk("zero_tix_success", success, 0);

    book(1'b1, 3'd0, 3'd1, 4'd9);
    chk("over_success", success, 0);
    chk("over_booked", booked_count, 2);

    book(1'b1, 3'd0, 3'd1, 4'd8);
    chk("full_success", success, 1);
    chk("full_fare", fare, 48);
    chk("full_booked", booked_count, 10);

    book(1'b1, 3'd0, 3'd1, 4'd1);
    chk("past_full_success", success, 0);
    chk("past_full_booked", booked_count, 10);

    book(1'b0, 3'd1, 3'd2, 4'd1);
    chk("t0_success", success, 1);
    chk("t0_fare", fare, 5);
    chk("t0_booked", booked_count, 1);

    // Fifth fault: full recovery on the same edge as a booking that must be dropped.
    force dut.fdu.fault_flag = 1'b1;
    #7;
    release dut.fdu.fault_flag;
    @(negedge clk);
    book(1'b0, 3'd0, 3'd1, 4'd1);
    chk("drop_trigger", heal_trigger, 1);
    chk("drop_success", success, 0);
    chk("drop_booked", booked_count, 0);
    chk("drop_fare", fare, 0);
    @(negedge clk);

    // Reset with a heal pending: no pulse may follow.
    book(1'b0, 3'd0, 3'd3, 4'd2);
    chk("pre_rst_fare", fare, 30);
    force dut.fdu.fault_flag = 1'b1;
    #7;
    release dut.fdu.fault_flag;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_success", success, 0);
    chk("arst_fare", fare, 0);
    chk("arst_booked", booked_count, 0);
    chk("arst_predict", predict_flag, 0);
    chk("arst_mode", heal_mode, 0);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_trigger", heal_trigger, 0);
    @(negedge clk);
    chk("abort_trigger2", heal_trigger, 0);
    chk("abort_mode", heal_mode, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
